// File: rtl/ariane_regfile_lvt.sv
// Multi-ported register file: one BRAM bank per write port, replicated per read port, with a
// live-value table selecting the bank that holds each word. REGFILE_BYPASS_EN adds forwarding.
module ariane_regfile_lvt #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_WORDS      = 32,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter bit          ZERO_REG_ZERO  = 1'b0,
    localparam int unsigned AW = $clog2(NUM_WORDS),
    localparam int unsigned LW = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      test_en_i,
    output logic                                      init_done_o,
    input  logic [NR_READ_PORTS-1:0][AW-1:0]          raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    input  logic [NR_WRITE_PORTS-1:0][AW-1:0]         waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                 we_i
);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    logic [0:0]                        r_state;
    logic [AW-1:0]                     r_ptr;
    logic [LW-1:0]                     r_lvt [NUM_WORDS];
    logic [NR_READ_PORTS-1:0][LW-1:0]  r_sel;
    logic [NR_READ_PORTS-1:0]          r_zero;
    logic [NR_WRITE_PORTS-1:0]         w_accept;
    logic                              w_ready;
    logic                              w_clearing;
    logic                              w_unused;
    logic [NR_WRITE_PORTS-1:0][NR_READ_PORTS-1:0][DATA_WIDTH-1:0] w_bank_q;

    assign w_unused    = test_en_i;
    assign w_ready     = (r_state == StReady) && !rst_i;
    assign w_clearing  = (r_state == StClear) && !rst_i;
    assign init_done_o = (r_state == StReady);

    always_comb begin
        w_accept = '0;
        for (int w = 0; w < NR_WRITE_PORTS; w++) begin
            w_accept[w] = we_i[w] && w_ready && !(ZERO_REG_ZERO && (waddr_i[w] == '0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StClear;
            r_ptr   <= '0;
        end else if (r_state == StClear) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == AW'(NUM_WORDS - 1)) begin
                r_state <= StReady;
            end
        end
    end

    // Ascending port order: the highest enabled port's assignment lands last and wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int a = 0; a < NUM_WORDS; a++) begin
                r_lvt[a] <= '0;
            end
        end else begin
            for (int w = 0; w < NR_WRITE_PORTS; w++) begin
                if (w_accept[w]) begin
                    r_lvt[waddr_i[w]] <= LW'(w);
                end
            end
        end
    end

    // Reads issued in reset or CLEAR return zero, which also masks stale bank-0 words.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            r_sel[r]  <= r_lvt[raddr_i[r]];
            r_zero[r] <= rst_i || (r_state == StClear) ||
                         (ZERO_REG_ZERO && (raddr_i[r] == '0));
        end
    end

    for (genvar w = 0; w < NR_WRITE_PORTS; w++) begin : g_bank
        logic                  w_we;
        logic [AW-1:0]         w_addr;
        logic [DATA_WIDTH-1:0] w_data;

        if (w == 0) begin : g_clr
            assign w_we   = w_accept[0] || w_clearing;
            assign w_addr = w_clearing ? r_ptr : waddr_i[0];
            assign w_data = w_clearing ? '0 : wdata_i[0];
        end else begin : g_plain
            assign w_we   = w_accept[w];
            assign w_addr = waddr_i[w];
            assign w_data = wdata_i[w];
        end

        for (genvar r = 0; r < NR_READ_PORTS; r++) begin : g_rep
            logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge clk_i) begin
                if (w_we) begin
                    r_mem[w_addr] <= w_data;
                end
                r_q <= r_mem[raddr_i[r]];
            end

            assign w_bank_q[w][r] = r_q;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NR_READ_PORTS-1:0]                 w_byp_hit;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] w_byp_data;
    logic [NR_READ_PORTS-1:0]                 r_byp_hit;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] r_byp_data;

    always_comb begin
        w_byp_hit  = '0;
        w_byp_data = '0;
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            for (int w = 0; w < NR_WRITE_PORTS; w++) begin
                if (w_accept[w] && (waddr_i[w] == raddr_i[r])) begin
                    w_byp_hit[r]  = 1'b1;
                    w_byp_data[r] = wdata_i[w];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r_byp_hit  <= w_byp_hit;
        r_byp_data <= w_byp_data;
    end
`endif

    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            if (!r_zero[r]) begin
                for (int w = 0; w < NR_WRITE_PORTS; w++) begin
                    if (r_sel[r] == LW'(w)) begin
                        rdata_o[r] = w_bank_q[w][r];
                    end
                end
`ifdef REGFILE_BYPASS_EN
                if (r_byp_hit[r]) begin
                    rdata_o[r] = r_byp_data[r];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ariane_regfile_lvt.sv
// Scoreboard bench: a 2R/2W instance and a 4R/3W ZERO_REG_ZERO instance share one stimulus
// stream and are checked against an array model of the register file.
module tb_ariane_regfile_lvt;

    localparam int NW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             test_en;
    logic [3:0][4:0]  raddr;
    logic [2:0][4:0]  waddr;
    logic [2:0][31:0] wdata;
    logic [2:0]       we;
    logic             done0;
    logic             done1;
    logic [1:0][31:0] rdata0;
    logic [3:0][31:0] rdata1;

    ariane_regfile_lvt #(
        .DATA_WIDTH(32), .NUM_WORDS(NW), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
        .ZERO_REG_ZERO(1'b0)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .init_done_o(done0),
        .raddr_i(raddr[1:0]), .rdata_o(rdata0), .waddr_i(waddr[1:0]),
        .wdata_i(wdata[1:0]), .we_i(we[1:0])
    );

    ariane_regfile_lvt #(
        .DATA_WIDTH(32), .NUM_WORDS(NW), .NR_READ_PORTS(4), .NR_WRITE_PORTS(3),
        .ZERO_REG_ZERO(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .init_done_o(done1),
        .raddr_i(raddr), .rdata_o(rdata1), .waddr_i(waddr),
        .wdata_i(wdata), .we_i(we)
    );

    typedef struct packed {
        int unsigned      due;
        logic             done;
        logic [1:0][31:0] d0;
        logic [3:0][31:0] d1;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_e;
    logic [31:0] mdl [2][NW];
    int unsigned clr_left = NW;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    endtask

    // Model: a word array per instance; a reset zeroes it and opens a NW-cycle window in
    // which reads return 0 and writes are dropped.
    task automatic step();
        exp_t        e;
        logic [31:0] v;
        int          nrp;
        int          nwp;
        bit          zrz;
        bit          ready;
        e = '0;
        e.due = cyc + 1;
        ready = (clr_left == 0) && !rst;
        for (int i = 0; i < 2; i++) begin
            nrp = (i == 0) ? 2 : 4;
            nwp = (i == 0) ? 2 : 3;
            zrz = (i == 1);
            for (int r = 0; r < nrp; r++) begin
                v = '0;
                if (ready && !(zrz && raddr[r] == 0)) begin
                    v = mdl[i][raddr[r]];
`ifdef REGFILE_BYPASS_EN
                    for (int w = 0; w < nwp; w++)
                        if (we[w] && waddr[w] == raddr[r] && !(zrz && waddr[w] == 0))
                            v = wdata[w];
`endif
                end
                if (i == 0) e.d0[r] = v;
                else e.d1[r] = v;
            end
            if (ready)
                for (int w = 0; w < nwp; w++)
                    if (we[w] && !(zrz && waddr[w] == 0)) mdl[i][waddr[w]] = wdata[w];
            if (rst)
                for (int a = 0; a < NW; a++) mdl[i][a] = '0;
        end
        if (rst) clr_left = NW;
        else if (clr_left > 0) clr_left--;
        e.done = (clr_left == 0);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            m_e = sb_q.pop_front();
            if (m_e.due != cyc) begin
                n_chk++;
                $display("FAIL stale_entry cyc=%0d got_due=%0d expected_due=%0d", cyc, m_e.due, cyc);
            end else begin
                check("dut0.init_done", {31'd0, done0}, {31'd0, m_e.done});
                check("dut1.init_done", {31'd0, done1}, {31'd0, m_e.done});
                for (int r = 0; r < 2; r++)
                    check($sformatf("dut0.rdata[%0d]", r), rdata0[r], m_e.d0[r]);
                for (int r = 0; r < 4; r++)
                    check($sformatf("dut1.rdata[%0d]", r), rdata1[r], m_e.d1[r]);
            end
        end
    end

    task automatic tick();
        step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        we    = '0;
        raddr = '0;
        waddr = '0;
        wdata = '0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, NW - 1));
    endfunction

    task automatic rand_traffic(input int n, input int rst_per_1000);
        for (int k = 0; k < n; k++) begin
            rst = ($urandom_range(0, 999) < rst_per_1000);
            for (int r = 0; r < 4; r++) raddr[r] = rnd_addr();
            for (int w = 0; w < 3; w++) begin
                waddr[w] = rnd_addr();
                wdata[w] = $urandom;
                we[w]    = ($urandom_range(0, 1) == 1);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic sweep();
        for (int a = 0; a < NW; a++) begin
            idle();
            for (int r = 0; r < 4; r++) raddr[r] = 5'(a);
            tick();
        end
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p]    = 1'b1;
        waddr[p] = a;
        wdata[p] = d;
    endtask

    task automatic rd_all(input logic [4:0] a);
        for (int r = 0; r < 4; r++) raddr[r] = a;
    endtask

    initial begin
        rst = 1'b1;
        test_en = 1'b0;
        idle();
        @(posedge clk);
        #2;
        tick();
        tick();
        rst = 1'b0;
        rand_traffic(34, 0);
        sweep();

        // Port spread
        idle(); wr(0, 5'd5, 32'hDEADBEEF); wr(1, 5'd9, 32'h12345678); tick();
        idle(); raddr[0] = 5'd9; raddr[1] = 5'd5; raddr[2] = 5'd5; raddr[3] = 5'd9; tick();
        // Conflict, then LVT move back to port 0
        idle(); wr(0, 5'd7, 32'h1111); wr(1, 5'd7, 32'h2222); tick();
        idle(); rd_all(5'd7); tick();
        idle(); wr(0, 5'd7, 32'h3333); tick();
        idle(); rd_all(5'd7); tick();
        idle(); wr(2, 5'd7, 32'h4444); wr(1, 5'd7, 32'h5555); tick();
        idle(); rd_all(5'd7); tick();
        // Same-cycle read-after-write
        idle(); wr(0, 5'd3, 32'hA); tick();
        idle(); wr(1, 5'd3, 32'hB); rd_all(5'd3); tick();
        idle(); rd_all(5'd3); tick();
        // Address zero
        idle(); wr(0, 5'd0, 32'hFFFF); rd_all(5'd0); tick();
        idle(); rd_all(5'd0); tick();
        idle(); tick();

        // Reset mid-CLEAR at ptr=10, with writes attempted throughout
        rst = 1'b1; tick(); rst = 1'b0;
        rand_traffic(10, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        rand_traffic(34, 0);
        sweep();
        // Reset mid-traffic
        rand_traffic(50, 0);
        rst = 1'b1; rand_traffic(1, 1000);
        rand_traffic(40, 0);
        sweep();

        rand_traffic(10000, 1);
        idle();
        tick();

        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
